// File: rtl/gate_sweep_if.sv
// gate_sweep_if: control, truth-table and gate-facing signals of the gate sweep sequencer
interface gate_sweep_if #(parameter int N_IN = 2);
  logic                 start;
  logic                 abort;
  logic [2**N_IN-1:0]   truth_tbl;
  logic                 gate_y;
  logic [N_IN-1:0]      gate_in;
  logic                 vec_valid;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        err_cnt;
  logic [N_IN-1:0]      first_err_vec;
  modport master (
    output start, abort, truth_tbl, gate_y,
    input  gate_in, vec_valid, busy, done, pass, err_cnt, first_err_vec
  );
  modport slave (
    input  start, abort, truth_tbl, gate_y,
    output gate_in, vec_valid, busy, done, pass, err_cnt, first_err_vec
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: steps a gate through every input vector, checks it against a truth table
module gate_sweep_ctrl #(
  parameter int N_IN = 2,
  parameter int HOLD = 5
) (
  input logic        clk,
  input logic        rst_n,
  gate_sweep_if.slave bus
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d, first_q, first_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [2**N_IN-1:0]  tbl_q, tbl_d;
  logic [N_IN:0]       err_q, err_d;
  logic                pass_q, pass_d;
  logic                last_hold;
  assign last_hold = hold_q == HW'(HOLD - 1);
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    if (state_q != DRIVE && bus.start) begin
      state_d = DRIVE;
      tbl_d   = bus.truth_tbl;
      vec_d   = '0;
      hold_d  = '0;
      err_d   = '0;
      first_d = '0;
      pass_d  = 1'b0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == DRIVE) begin
      if (bus.abort) begin
        state_d = IDLE;
        pass_d  = 1'b0;
      end else if (last_hold) begin
        if (bus.gate_y != tbl_q[vec_q]) begin
          err_d   = err_q + 1'b1;
          first_d = err_q == '0 ? vec_q : first_q;
        end
        // pass reflects the count including the final vector's compare
        if (&vec_q) begin
          state_d = DONE;
          pass_d  = err_d == '0;
        end else begin
          vec_d  = vec_q + 1'b1;
          hold_d = '0;
        end
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      tbl_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end
  assign bus.gate_in       = state_q == DRIVE ? vec_q : '0;
  assign bus.vec_valid     = state_q == DRIVE;
  assign bus.busy          = state_q == DRIVE;
  assign bus.done          = state_q == DONE;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_vec = first_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed sweeps with a done-time/result scoreboard and a gate_in sequence monitor
module tb_gate_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_sweep_if #(.N_IN(2)) a_if ();
  gate_sweep_if #(.N_IN(3)) b_if ();

  gate_sweep_ctrl #(.N_IN(2), .HOLD(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  gate_sweep_ctrl #(.N_IN(3), .HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  // 0 = OR, 1 = stuck-at-0, 2 = AND
  int mode;
  assign a_if.gate_y = mode == 0 ? |a_if.gate_in : mode == 1 ? 1'b0 : &a_if.gate_in;
  assign b_if.gate_y = ^b_if.gate_in;

  typedef struct {int due; int err; int first; int pass;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int ncyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int busy_a = 0;
  int busy_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit to_b, input int due, input int err, input int first, input int pass);
    exp_t e;
    e.due = due; e.err = err; e.first = first; e.pass = pass;
    if (to_b) qb.push_back(e); else qa.push_back(e);
  endtask

  task automatic go_a(input logic [3:0] tbl, input int m, input int err, input int first, input int pass);
    a_if.truth_tbl = tbl;
    mode = m;
    a_if.start = 1'b1;
    push(1'b0, ncyc + 22, err, first, pass);
    tick(1);
    a_if.start = 1'b0;
    a_if.truth_tbl = ~tbl;
  endtask

  task automatic go_b(input logic [7:0] tbl, input int err, input int first, input int pass);
    b_if.truth_tbl = tbl;
    b_if.start = 1'b1;
    push(1'b1, ncyc + 10, err, first, pass);
    tick(1);
    b_if.start = 1'b0;
    b_if.truth_tbl = ~tbl;
  endtask

  task automatic wait_a(input int left);
    int t = 0;
    while (qa.size() > left && t < 100) begin tick(1); t++; end
    chk("done_timeout_a", qa.size(), left);
  endtask

  task automatic wait_b();
    int t = 0;
    while (qb.size() > 0 && t < 100) begin tick(1); t++; end
    chk("done_timeout_b", qb.size(), 0);
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (a_if.busy) begin
      chk("gate_in_a", a_if.gate_in, busy_a / 5);
      chk("vec_valid_a", a_if.vec_valid, 1);
      busy_a++;
    end else busy_a = 0;
    if (b_if.busy) begin
      chk("gate_in_b", b_if.gate_in, busy_b);
      busy_b++;
    end else busy_b = 0;
    if (a_if.done) begin
      if (qa.size() == 0) chk("stray_done_a", a_if.done, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("done_time_a", ncyc, e.due);
        chk("err_cnt_a", a_if.err_cnt, e.err);
        chk("first_err_a", a_if.first_err_vec, e.first);
        chk("pass_a", a_if.pass, e.pass);
        chk("done_gate_in_a", {a_if.vec_valid, a_if.gate_in}, 0);
      end
    end
    if (b_if.done) begin
      if (qb.size() == 0) chk("stray_done_b", b_if.done, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("done_time_b", ncyc, e.due);
        chk("err_cnt_b", b_if.err_cnt, e.err);
        chk("first_err_b", b_if.first_err_vec, e.first);
        chk("pass_b", b_if.pass, e.pass);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    mode = 0;
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.truth_tbl = '0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.truth_tbl = '0;
    tick(3);
    chk("rst_gate_in_a", a_if.gate_in, 0);
    chk("rst_flags_a", {a_if.vec_valid, a_if.busy, a_if.done, a_if.pass}, 0);
    chk("rst_err_cnt_a", a_if.err_cnt, 0);
    chk("rst_first_a", a_if.first_err_vec, 0);
    chk("rst_state_b", {b_if.busy, b_if.done, b_if.pass, b_if.err_cnt}, 0);
    rst_n = 1'b1;
    tick(1);
    // OR gate, stuck-at-0, AND against OR table
    go_a(4'b1110, 0, 0, 0, 1); wait_a(0);
    tick(2);
    chk("pass_held_a", a_if.pass, 1);
    go_a(4'b1110, 1, 3, 1, 0); wait_a(0);
    go_a(4'b1110, 2, 2, 1, 0); wait_a(0);
    tick(2);
    // reset mid-sweep after one error has been counted
    mode = 1; a_if.truth_tbl = 4'b1111; a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    tick(6);
    chk("partial_err_a", a_if.err_cnt, 1);
    chk("mid_busy_a", a_if.busy, 1);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst_mid_busy_a", {a_if.busy, a_if.vec_valid, a_if.gate_in}, 0);
    chk("rst_mid_err_a", {a_if.err_cnt, a_if.pass}, 0);
    tick(2);
    go_a(4'b1110, 0, 0, 0, 1); wait_a(0);
    // ignored restart during sweep, then abort with a partial count
    mode = 1; a_if.truth_tbl = 4'b1110; a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    tick(2);
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    tick(7);
    a_if.abort = 1'b1;
    tick(1);
    a_if.abort = 1'b0;
    chk("abort_busy_a", {a_if.busy, a_if.gate_in}, 0);
    chk("abort_pass_a", a_if.pass, 0);
    chk("abort_err_a", a_if.err_cnt, 1);
    tick(25);
    chk("abort_idle_a", a_if.busy, 0);
    // back-to-back sweeps with start held through DONE
    mode = 0; a_if.truth_tbl = 4'b1110; a_if.start = 1'b1;
    push(1'b0, ncyc + 22, 0, 0, 1);
    push(1'b0, ncyc + 43, 0, 0, 1);
    wait_a(1);
    a_if.start = 1'b0;
    chk("b2b_busy_a", a_if.busy, 1);
    wait_a(0);
    // HOLD=1, N_IN=3 XOR3: matching table, then one flipped entry
    go_b(8'b1001_0110, 0, 0, 1); wait_b();
    go_b(8'b1101_0110, 1, 6, 0); wait_b();
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
